// File: rtl/arm_pkg.sv
// Shared definitions for the ARM condition/flag logic: condition codes, NZCV bit
// positions and the pending-flag state encoding.
package arm_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/arm_cond_eval.sv
// Combinational ARM condition-field evaluator: decides pass/fail of a 4-bit condition
// against an {N,Z,C,V} flag set. Shared with the branch unit.
module arm_cond_eval
  import arm_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_cond_flag_unit.sv
// NZCV flag holder and issue interlock: evaluates instruction conditions, tracks one
// in-flight flag-setting instruction and absorbs the ALU flag writeback.
module arm_cond_flag_unit
  import arm_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       issue_valid_i,
  output logic       issue_ready_o,
  input  logic [3:0] issue_cond_i,
  input  logic       issue_s_i,
  output logic       exec_valid_o,
  output logic       exec_pass_o,
  output logic       alu_cin_o,
  input  logic       alu_flags_valid_i,
  input  logic [3:0] alu_nzcv_i,
  input  logic       flag_wr_en_i,
  input  logic [3:0] flag_wr_data_i,
  output logic [3:0] flags_o,
  output logic       err_spurious_o
);

  localparam int unsigned CntW = 3;

  state_e          state_q, state_d;
  logic [3:0]      flags_q, flags_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            exec_valid_q, exec_pass_q, err_q;

  logic       pending, flag_ret, accept, pass, set_pend;
  logic [3:0] eff_nzcv;

  assign pending  = (state_q == ST_WAIT);
  assign flag_ret = alu_flags_valid_i & pending;
  // Returning flags are bypassed so a dependent instruction can issue in the release cycle.
  assign eff_nzcv = flag_ret ? alu_nzcv_i : flags_q;

  assign issue_ready_o = ~pending | alu_flags_valid_i;
  assign accept        = issue_valid_i & issue_ready_o;
  assign set_pend      = accept & issue_s_i & pass;

  arm_cond_eval u_cond_eval (
    .cond_i (issue_cond_i),
    .nzcv_i (eff_nzcv),
    .pass_o (pass)
  );

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flag_wr_en_i) flags_d = flag_wr_data_i;
        if (set_pend) begin
          state_d = ST_WAIT;
          cnt_d   = CntW'(ALU_LAT);
        end
      end
      ST_WAIT: begin
        // Counter is observational only; a late ALU return simply keeps us waiting.
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
        if (alu_flags_valid_i) begin
          flags_d = alu_nzcv_i;
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (set_pend) begin
            state_d = ST_WAIT;
            cnt_d   = CntW'(ALU_LAT);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      flags_q      <= '0;
      cnt_q        <= '0;
      exec_valid_q <= 1'b0;
      exec_pass_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      cnt_q        <= cnt_d;
      exec_valid_q <= accept;
      exec_pass_q  <= accept & pass;
      err_q        <= alu_flags_valid_i & ~pending;
    end
  end

  assign exec_valid_o   = exec_valid_q;
  assign exec_pass_o    = exec_pass_q;
  assign alu_cin_o      = flags_q[FLAG_C];
  assign flags_o        = flags_q;
  assign err_spurious_o = err_q;

endmodule

// File: tb/tb_arm_cond_flag_unit.sv
// Self-checking bench for arm_cond_flag_unit: condition table, directed corner
// sequences and a random run against a transaction-level flag model.
module tb_arm_cond_flag_unit;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       issue_valid_i;
  logic       issue_ready_o;
  logic [3:0] issue_cond_i;
  logic       issue_s_i;
  logic       exec_valid_o;
  logic       exec_pass_o;
  logic       alu_cin_o;
  logic       alu_flags_valid_i;
  logic [3:0] alu_nzcv_i;
  logic       flag_wr_en_i;
  logic [3:0] flag_wr_data_i;
  logic [3:0] flags_o;
  logic       err_spurious_o;

  int errors = 0;
  int checks = 0;

  arm_cond_flag_unit #(.ALU_LAT(1)) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_cond_i      (issue_cond_i),
    .issue_s_i         (issue_s_i),
    .exec_valid_o      (exec_valid_o),
    .exec_pass_o       (exec_pass_o),
    .alu_cin_o         (alu_cin_o),
    .alu_flags_valid_i (alu_flags_valid_i),
    .alu_nzcv_i        (alu_nzcv_i),
    .flag_wr_en_i      (flag_wr_en_i),
    .flag_wr_data_i    (flag_wr_data_i),
    .flags_o           (flags_o),
    .err_spurious_o    (err_spurious_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] nzcv;
    logic       exp;
  } vec_t;

  // Odd condition codes are the inverse of the even code below them (AL/NV aside).
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    return base ^ c[0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    reset_i = 1'b0; issue_valid_i = 1'b0; issue_cond_i = 4'hE; issue_s_i = 1'b0;
    alu_flags_valid_i = 1'b0; alu_nzcv_i = 4'h0; flag_wr_en_i = 1'b0; flag_wr_data_i = 4'h0;
  endtask

  // Advance past one rising edge; leaves time 1 unit after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic s);
    issue_valid_i = 1'b1; issue_cond_i = c; issue_s_i = s;
  endtask

  task automatic write_flags(input logic [3:0] f);
    flag_wr_en_i = 1'b1; flag_wr_data_i = f;
    tick();
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
  endtask

  vec_t tbl[$];
  logic [3:0] sweep_c[5];

  // Model state for the random phase
  logic [3:0] m_flags;
  logic       m_pend, m_ev, m_ep, m_err;

  initial begin
    tbl = '{
      '{4'h0, 4'b0100, 1'b1}, '{4'h0, 4'b0000, 1'b0}, '{4'h1, 4'b0100, 1'b0},
      '{4'h2, 4'b0010, 1'b1}, '{4'h3, 4'b0010, 1'b0}, '{4'h4, 4'b1000, 1'b1},
      '{4'h5, 4'b1000, 1'b0}, '{4'h6, 4'b0001, 1'b1}, '{4'h7, 4'b0000, 1'b1},
      '{4'h8, 4'b0010, 1'b1}, '{4'h8, 4'b0110, 1'b0}, '{4'h9, 4'b0000, 1'b1},
      '{4'h9, 4'b0010, 1'b0}, '{4'hA, 4'b1001, 1'b1}, '{4'hA, 4'b1000, 1'b0},
      '{4'hB, 4'b1000, 1'b1}, '{4'hC, 4'b0000, 1'b1}, '{4'hC, 4'b0100, 1'b0},
      '{4'hD, 4'b0100, 1'b1}, '{4'hD, 4'b0001, 1'b1}, '{4'hE, 4'b0000, 1'b1},
      '{4'hF, 4'b1111, 1'b0}
    };
    sweep_c = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hF};

    idle_inputs();
    do_reset();

    // 1: reset state and AL issue
    #1;
    chk("rst_flags", flags_o, 4'h0);
    chk("rst_exec_valid", exec_valid_o, 1'b0);
    chk("rst_exec_pass", exec_pass_o, 1'b0);
    chk("rst_err", err_spurious_o, 1'b0);
    chk("rst_ready", issue_ready_o, 1'b1);
    chk("rst_cin", alu_cin_o, 1'b0);
    issue(4'hE, 1'b0);
    tick(); idle_inputs(); #1;
    chk("al_exec_valid", exec_valid_o, 1'b1);
    chk("al_exec_pass", exec_pass_o, 1'b1);
    chk("al_flags", flags_o, 4'h0);
    tick();
    chk("al_one_pulse", exec_valid_o, 1'b0);

    // Condition table
    foreach (tbl[i]) begin
      write_flags(tbl[i].nzcv);
      issue(tbl[i].cond, 1'b0);
      tick(); idle_inputs(); #1;
      chk($sformatf("tbl%0d_valid", i), exec_valid_o, 1'b1);
      chk($sformatf("tbl%0d_pass", i), exec_pass_o, tbl[i].exp);
    end

    // 2: EQ then NE back-to-back with Z set
    write_flags(4'b0100);
    issue(4'h0, 1'b0);
    tick(); issue(4'h1, 1'b0); #1;
    chk("eq_pass", exec_pass_o, 1'b1);
    tick(); idle_inputs(); #1;
    chk("ne_valid", exec_valid_o, 1'b1);
    chk("ne_pass", exec_pass_o, 1'b0);
    chk("eqne_flags", flags_o, 4'b0100);

    // 3: passed S, ALU returns 0010 one cycle later, CS issued in release cycle
    issue(4'hE, 1'b1);
    tick(); idle_inputs(); #1;
    chk("s_ready_low", issue_ready_o, 1'b0);
    alu_flags_valid_i = 1'b1; alu_nzcv_i = 4'b0010;
    issue(4'h2, 1'b0); #1;
    chk("s_ready_release", issue_ready_o, 1'b1);
    tick(); idle_inputs(); #1;
    chk("bypass_valid", exec_valid_o, 1'b1);
    chk("bypass_pass", exec_pass_o, 1'b1);
    chk("wb_flags", flags_o, 4'b0010);
    chk("wb_cin", alu_cin_o, 1'b1);
    chk("wb_ready", issue_ready_o, 1'b1);
    chk("wb_no_err", err_spurious_o, 1'b0);

    // 4: failed-cond S sets nothing; stray return is spurious
    issue(4'h0, 1'b1);
    tick(); idle_inputs(); #1;
    chk("fail_s_pass", exec_pass_o, 1'b0);
    chk("fail_s_ready", issue_ready_o, 1'b1);
    alu_flags_valid_i = 1'b1; alu_nzcv_i = 4'b1111;
    tick(); idle_inputs(); #1;
    chk("spur_err", err_spurious_o, 1'b1);
    chk("spur_flags", flags_o, 4'b0010);
    tick();
    chk("spur_one_pulse", err_spurious_o, 1'b0);

    // 5: direct write ignored in WAIT, ALU wins, IDLE write lands
    issue(4'hE, 1'b1);
    tick(); idle_inputs();
    flag_wr_en_i = 1'b1; flag_wr_data_i = 4'b1111;
    tick(); #1;
    chk("wait_wr_ignored", flags_o, 4'b0010);
    alu_flags_valid_i = 1'b1; alu_nzcv_i = 4'b1000;
    tick(); idle_inputs(); #1;
    chk("alu_beats_wr", flags_o, 4'b1000);
    write_flags(4'b1111); #1;
    chk("idle_wr", flags_o, 4'b1111);

    // 6: reset while WAIT with exec_valid high
    issue(4'hE, 1'b1);
    tick(); idle_inputs(); #1;
    chk("pre_rst_valid", exec_valid_o, 1'b1);
    reset_i = 1'b1;
    tick(); reset_i = 1'b0; #1;
    chk("mid_rst_flags", flags_o, 4'h0);
    chk("mid_rst_valid", exec_valid_o, 1'b0);
    chk("mid_rst_pass", exec_pass_o, 1'b0);
    chk("mid_rst_ready", issue_ready_o, 1'b1);
    chk("mid_rst_err", err_spurious_o, 1'b0);
    alu_flags_valid_i = 1'b1; alu_nzcv_i = 4'b0110;
    tick(); idle_inputs(); #1;
    chk("post_rst_spur", err_spurious_o, 1'b1);
    chk("post_rst_flags", flags_o, 4'h0);

    // 7: GE/LT/GT/LE/NV sweep over all flag values
    foreach (sweep_c[k]) begin
      for (int f = 0; f < 16; f++) begin
        write_flags(4'(f));
        issue(sweep_c[k], 1'b0);
        tick(); idle_inputs(); #1;
        chk($sformatf("sweep_c%0h_f%0h", sweep_c[k], f), exec_pass_o,
            ref_pass(sweep_c[k], 4'(f)));
      end
    end

    // Random traffic against the flag model
    m_flags = '0; m_pend = 0; m_ev = 0; m_ep = 0; m_err = 0;
    reset_i = 1'b1;
    tick();
    for (int i = 0; i < 3000; i++) begin
      logic rdy, ret, pass, acc;
      logic [3:0] eff;
      reset_i           = ($urandom_range(0, 63) == 0);
      issue_valid_i     = $urandom_range(0, 1);
      issue_cond_i      = 4'($urandom_range(0, 15));
      issue_s_i         = $urandom_range(0, 1);
      alu_flags_valid_i = m_pend ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      alu_nzcv_i        = 4'($urandom_range(0, 15));
      flag_wr_en_i      = ($urandom_range(0, 3) == 0);
      flag_wr_data_i    = 4'($urandom_range(0, 15));
      #1;
      rdy = !m_pend || alu_flags_valid_i;
      chk("rnd_ready", issue_ready_o, rdy);
      chk("rnd_flags", flags_o, m_flags);
      chk("rnd_cin", alu_cin_o, m_flags[1]);
      chk("rnd_exec_valid", exec_valid_o, m_ev);
      chk("rnd_exec_pass", exec_pass_o, m_ep);
      chk("rnd_err", err_spurious_o, m_err);
      ret  = alu_flags_valid_i && m_pend;
      eff  = ret ? alu_nzcv_i : m_flags;
      acc  = issue_valid_i && rdy;
      pass = ref_pass(issue_cond_i, eff);
      if (reset_i) begin
        m_flags = '0; m_pend = 0; m_ev = 0; m_ep = 0; m_err = 0;
      end else begin
        m_ev  = acc;
        m_ep  = acc && pass;
        m_err = alu_flags_valid_i && !m_pend;
        if (ret) m_flags = alu_nzcv_i;
        else if (!m_pend && flag_wr_en_i) m_flags = flag_wr_data_i;
        if (acc && issue_s_i && pass) m_pend = 1;
        else if (ret) m_pend = 0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
